// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter, one bit per
//               clock, with start/ready/done handshake and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq #(
  parameter int WIDTH  = 35,
  parameter int DIGITS = 11
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    data,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shreg_shifted;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_shifted;
  logic [CNT_W-1:0]  cnt;
  logic              sticky;
  logic              spill;
  logic              last_bit;

  // Add-3 correction per digit; no carry crosses a digit boundary.
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      assign acc_adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? (acc[4*k +: 4] + 4'd3)
                                                        : acc[4*k +: 4];
    end
  endgenerate

  // The bit leaving the top digit means the value exceeds DIGITS digits.
  assign {spill, acc_shifted, shreg_shifted} = {acc_adj, shreg, 1'b0};
  assign last_bit = (cnt == CNT_W'(1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are flopped from the next state so they align with it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      done  <= (state_next == DONE);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= data;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          shreg  <= shreg_shifted;
          acc    <= acc_shifted;
          sticky <= sticky | spill;
          cnt    <= cnt - CNT_W'(1);
          // Result is published on the edge entering DONE so it is valid with done.
          if (last_bit) begin
            bcd      <= acc_shifted;
            overflow <= sticky | spill;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// Testbench for binary_to_bcd_seq: a 35-bit/11-digit and an 8-bit/2-digit instance.
module tb_binary_to_bcd_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;

  logic        start_b = 1'b0;
  logic [34:0] data_b  = '0;
  logic        ready_b, done_b, overflow_b;
  logic [43:0] bcd_b;

  logic        start_s = 1'b0;
  logic [7:0]  data_s  = '0;
  logic        ready_s, done_s, overflow_s;
  logic [7:0]  bcd_s;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  binary_to_bcd_seq #(.WIDTH(35), .DIGITS(11)) dut_big (
    .Clk(Clk), .Rst(Rst), .start(start_b), .data(data_b),
    .ready(ready_b), .done(done_b), .bcd(bcd_b), .overflow(overflow_b)
  );

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_small (
    .Clk(Clk), .Rst(Rst), .start(start_s), .data(data_s),
    .ready(ready_s), .done(done_s), .bcd(bcd_s), .overflow(overflow_s)
  );

  typedef struct {
    logic        sel;
    logic [34:0] d;
    logic [43:0] eb;
    logic        eo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      checks++;
      if ((done_b && ready_b) || (done_s && ready_s)) begin
        errors++;
        $display("FAIL done_ready_overlap: big %b%b small %b%b expected never both 1",
                 done_b, ready_b, done_s, ready_s);
      end
    end
  end

  task automatic convert(input logic sel, input logic [34:0] d, input logic [43:0] eb,
                         input logic eo);
    int lat;
    int w;
    bit seen;
    w = sel ? 8 : 35;
    @(negedge Clk);
    chk("ready_before_start", sel ? 44'(ready_s) : 44'(ready_b), 44'd1);
    if (sel) begin start_s = 1'b1; data_s = d[7:0]; end
    else     begin start_b = 1'b1; data_b = d;      end
    @(negedge Clk);
    start_s = 1'b0;
    start_b = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (lat <= 60 && !seen) begin
      if (sel ? done_s : done_b) seen = 1'b1;
      else begin
        @(negedge Clk);
        lat++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 60 cycles for data %0d", d);
      return;
    end
    chk("latency", 44'(lat), 44'(w + 1));
    chk("bcd", sel ? 44'(bcd_s) : bcd_b, sel ? 44'(eb[7:0]) : eb);
    chk("overflow", sel ? 44'(overflow_s) : 44'(overflow_b), 44'(eo));
    chk("ready_during_done", sel ? 44'(ready_s) : 44'(ready_b), 44'd0);
    @(negedge Clk);
    chk("done_one_cycle", sel ? 44'(done_s) : 44'(done_b), 44'd0);
    chk("ready_after_done", sel ? 44'(ready_s) : 44'(ready_b), 44'd1);
    chk("bcd_hold", sel ? 44'(bcd_s) : bcd_b, sel ? 44'(eb[7:0]) : eb);
  endtask

  initial begin
    int cyc;
    int dones;
    int lat;
    int d1;
    int d2;

    vecs[0] = '{1'b0, 35'd0,           44'h000_0000_0000, 1'b0};
    vecs[1] = '{1'b0, 35'h7_FFFF_FFFF, 44'h343_5973_8367, 1'b0};
    vecs[2] = '{1'b0, 35'd9999999999,  44'h099_9999_9999, 1'b0};
    vecs[3] = '{1'b0, 35'd1000,        44'h000_0000_1000, 1'b0};
    vecs[4] = '{1'b1, 35'd255,         44'h55,            1'b1};
    vecs[5] = '{1'b1, 35'd99,          44'h99,            1'b0};
    vecs[6] = '{1'b1, 35'd100,         44'h00,            1'b1};
    vecs[7] = '{1'b1, 35'd187,         44'h87,            1'b1};
    vecs[8] = '{1'b1, 35'd0,           44'h00,            1'b0};
    vecs[9] = '{1'b1, 35'd9,           44'h09,            1'b0};

    #12;
    chk("rst_ready", 44'(ready_b), 44'd1);
    chk("rst_done", 44'(done_b), 44'd0);
    chk("rst_bcd", bcd_b, 44'd0);
    chk("rst_overflow", 44'(overflow_b), 44'd0);
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].sel, vecs[i].d, vecs[i].eb, vecs[i].eo);
    end

    // Start while busy must be ignored, not queued.
    @(negedge Clk);
    start_b = 1'b1;
    data_b  = 35'd12345678;
    @(negedge Clk);
    start_b = 1'b0;
    dones = 0;
    lat   = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (done_b) begin
        dones++;
        if (lat == 0) lat = cyc;
      end
      if (cyc == 5) begin start_b = 1'b1; data_b = 35'd999; end
      if (cyc == 6) start_b = 1'b0;
      @(negedge Clk);
    end
    chk("busy_done_count", 44'(dones), 44'd1);
    chk("busy_latency", 44'(lat), 44'd36);
    chk("busy_bcd", bcd_b, 44'h000_1234_5678);
    chk("busy_overflow", 44'(overflow_b), 44'd0);

    // Asynchronous reset in the middle of a conversion.
    start_b = 1'b1;
    data_b  = 35'd5555;
    @(negedge Clk);
    start_b = 1'b0;
    for (cyc = 1; cyc < 20; cyc++) @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("abort_ready", 44'(ready_b), 44'd1);
    chk("abort_done", 44'(done_b), 44'd0);
    chk("abort_bcd", bcd_b, 44'd0);
    chk("abort_overflow", 44'(overflow_b), 44'd0);
    chk("abort_small_bcd", 44'(bcd_s), 44'd0);
    @(negedge Clk);
    Rst = 1'b0;
    dones = 0;
    for (cyc = 0; cyc < 50; cyc++) begin
      if (done_b) dones++;
      @(negedge Clk);
    end
    chk("abort_no_done", 44'(dones), 44'd0);
    convert(1'b0, 35'd1000, 44'h1000, 1'b0);

    // start held high: each conversion accepted only when ready.
    @(negedge Clk);
    start_b = 1'b1;
    data_b  = 35'd7;
    @(negedge Clk);
    data_b = 35'd42;
    dones = 0;
    d1 = 0;
    d2 = 0;
    for (cyc = 1; cyc <= 120; cyc++) begin
      if (done_b) begin
        dones++;
        if (dones == 1) begin
          d1 = cyc;
          chk("b2b_first", bcd_b, 44'h7);
        end else if (dones == 2) begin
          d2 = cyc;
          chk("b2b_second", bcd_b, 44'h42);
          start_b = 1'b0;
        end
      end
      @(negedge Clk);
    end
    chk("b2b_done_count", 44'(dones), 44'd2);
    chk("b2b_spacing", 44'(d2 - d1), 44'd37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
